// File: rtl/ucode_store_responder_pkg.sv
// Shared definitions for the microcode control store: loader state encoding,
// microword geometry and the byte-lane placement helper used by the loader.
package ucode_store_responder_pkg;

    localparam int UCODE_WW  = 24;
    localparam int UCODE_BPW = 3;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_B0    = 3'd1,
        ST_B1    = 3'd2,
        ST_B2    = 3'd3,
        ST_WR    = 3'd4
    } ld_state_e;

    // Lane 0 is the most significant byte; bytes arrive MSB first.
    function automatic logic [UCODE_WW-1:0] put_byte(
        input logic [UCODE_WW-1:0] word,
        input int unsigned         lane,
        input logic [BYTE_W-1:0]   data
    );
        logic [UCODE_WW-1:0] res;
        res = word;
        res[(UCODE_BPW - 1 - lane) * BYTE_W +: BYTE_W] = data;
        return res;
    endfunction

endpackage

// File: rtl/ucode_store_responder_mem.sv
// Simple 1R1W synchronous store: registered read, synchronous write.
// A same-address read and write in one cycle returns the old word.
module ucode_mem #(
    parameter int AW = 8,
    parameter int WW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata
);

    localparam int DEPTH = 2 ** AW;

    logic [WW-1:0] mem [DEPTH];

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ucode_store_responder.sv
// Microprogram control store responder: serves uPC fetches with a validity flag
// and accepts byte-serial loads that fill the store between runs.
module ucode_store_responder
    import ucode_store_responder_pkg::*;
#(
    parameter int AW = 8,
    parameter int WW = UCODE_WW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_rom,
    input  logic          wupc,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [WW-1:0] in_rom,
    output logic          in_rom_efficient,
    output logic          ld_busy,
    output logic          ld_err,
    output logic [AW-1:0] ld_count
);

    ld_state_e     state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] last_addr;
    logic [WW-1:0] hold;
    logic          last_flag;
    logic          fetched_ok;
    logic          xfer;

    // Loader handshake: a byte moves on any posedge where ld_valid & ld_ready;
    // ld_ready depends only on state, never on ld_valid, and the sender may not
    // retract or change ld_byte/ld_last while ld_valid is high and unaccepted.
    assign ld_ready = (state == ST_B0) || (state == ST_B1) || (state == ST_B2);
    assign xfer     = ld_valid & ld_ready;
    assign ld_busy  = (state != ST_FETCH);

    assign in_rom_efficient = (state == ST_FETCH) & fetched_ok & (last_addr == addr_rom);

    ucode_mem #(
        .AW (AW),
        .WW (WW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .re    (state == ST_FETCH),
        .raddr (addr_rom),
        .rdata (in_rom),
        .we    (state == ST_WR),
        .waddr (ptr),
        .wdata (hold)
    );

    // fetched_ok lags state by one edge, so re-entering FETCH forces a re-read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_ok <= 1'b0;
            last_addr  <= '0;
        end else begin
            fetched_ok <= (state == ST_FETCH);
            if (state == ST_FETCH) begin
                last_addr <= addr_rom;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            ptr       <= '0;
            hold      <= '0;
            last_flag <= 1'b0;
            ld_err    <= 1'b0;
            ld_count  <= '0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (ld_start && wupc) begin
                        ptr      <= ld_addr;
                        ld_count <= '0;
                        ld_err   <= 1'b0;
                        state    <= ST_B0;
                    end
                end
                ST_B0, ST_B1: begin
                    // Losing wupc or an early ld_last drops the partial word.
                    if (!wupc) begin
                        ld_err <= 1'b1;
                        state  <= ST_FETCH;
                    end else if (xfer) begin
                        hold <= put_byte(hold, (state == ST_B0) ? 0 : 1, ld_byte);
                        if (ld_last) begin
                            ld_err <= 1'b1;
                            state  <= ST_FETCH;
                        end else begin
                            state <= (state == ST_B0) ? ST_B1 : ST_B2;
                        end
                    end
                end
                ST_B2: begin
                    if (!wupc) begin
                        ld_err <= 1'b1;
                        state  <= ST_FETCH;
                    end else if (xfer) begin
                        hold      <= put_byte(hold, 2, ld_byte);
                        last_flag <= ld_last;
                        state     <= ST_WR;
                    end
                end
                ST_WR: begin
                    ptr      <= ptr + 1'b1;
                    ld_count <= ld_count + 1'b1;
                    state    <= last_flag ? ST_FETCH : ST_B0;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_store_responder.sv
// Self-checking bench for ucode_store_responder: loads, fetch latency and the
// efficient flag, abort paths, address wrap and asynchronous reset mid-load.
module tb_ucode_store_responder;

    localparam int AW = 8;
    localparam int WW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr_rom = '0;
    logic          wupc = 1'b0;
    logic          ld_start = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic [WW-1:0] in_rom;
    logic          in_rom_efficient;
    logic          ld_busy;
    logic          ld_err;
    logic [AW-1:0] ld_count;

    logic [WW-1:0] model [256];
    logic [WW-1:0] lw [4];
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] exp_w;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucode_store_responder #(.AW(AW), .WW(WW)) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_rom         (addr_rom),
        .wupc             (wupc),
        .ld_start         (ld_start),
        .ld_addr          (ld_addr),
        .ld_valid         (ld_valid),
        .ld_byte          (ld_byte),
        .ld_last          (ld_last),
        .ld_ready         (ld_ready),
        .in_rom           (in_rom),
        .in_rom_efficient (in_rom_efficient),
        .ld_busy          (ld_busy),
        .ld_err           (ld_err),
        .ld_count         (ld_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load of n words from lw[] with ld_valid held high every cycle.
    task automatic do_load(input logic [AW-1:0] base, input int n);
        wupc = 1'b1; ld_start = 1'b1; ld_addr = base;
        step();
        ld_start = 1'b0;
        checks++;
        if (ld_busy !== 1'b1 || ld_err !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("FAIL load_start: busy=%b err=%b count=%0d want 1 0 0", ld_busy, ld_err, ld_count);
        end
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 3; b++) begin
                ld_valid = 1'b1;
                ld_byte  = lw[w][23 - 8*b -: 8];
                ld_last  = (w == n - 1) && (b == 2);
                checks++;
                if (ld_ready !== 1'b1 || in_rom_efficient !== 1'b0) begin
                    errors++;
                    $display("FAIL load_byte w%0d b%0d: ready=%b eff=%b want 1 0", w, b, ld_ready, in_rom_efficient);
                end
                step();
            end
            ld_byte = 8'hEE;
            ld_last = 1'b0;
            checks++;
            if (ld_ready !== 1'b0 || ld_busy !== 1'b1 || in_rom_efficient !== 1'b0) begin
                errors++;
                $display("FAIL load_wr w%0d: ready=%b busy=%b eff=%b want 0 1 0", w, ld_ready, ld_busy, in_rom_efficient);
            end
            step();
            checks++;
            if (ld_count !== AW'(w + 1)) begin
                errors++;
                $display("FAIL load_count w%0d: got %0d want %0d", w, ld_count, w + 1);
            end
            model[AW'(base + w)] = lw[w];
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || in_rom_efficient !== 1'b0) begin
            errors++;
            $display("FAIL load_end: busy=%b ready=%b eff=%b want 0 0 0", ld_busy, ld_ready, in_rom_efficient);
        end
    endtask

    // Fetch one word through the scoreboard: expected pushed on drive, popped on valid output.
    task automatic fetch_check(input logic [AW-1:0] a);
        exp_q.push_back(model[a]);
        addr_rom = a;
        step();
        exp_w = exp_q.pop_front();
        checks++;
        if (in_rom_efficient !== 1'b1 || in_rom !== exp_w) begin
            errors++;
            $display("FAIL fetch %02h: eff=%b in_rom=%06h want 1 %06h", a, in_rom_efficient, in_rom, exp_w);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (in_rom !== '0 || in_rom_efficient !== 1'b0 || ld_ready !== 1'b0 ||
            ld_busy !== 1'b0 || ld_err !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("FAIL reset_state: rom=%h eff=%b rdy=%b busy=%b err=%b cnt=%h want all 0",
                     in_rom, in_rom_efficient, ld_ready, ld_busy, ld_err, ld_count);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_and_fetch();
        lw[0] = 24'hAABBCC;
        lw[1] = 24'h112233;
        addr_rom = 8'h10;
        do_load(8'h10, 2);
        fetch_check(8'h10);
    endtask

    task automatic test_addr_change();
        step();
        checks++;
        if (in_rom_efficient !== 1'b1 || in_rom !== 24'hAABBCC) begin
            errors++;
            $display("FAIL addr_hold: eff=%b in_rom=%06h want 1 aabbcc", in_rom_efficient, in_rom);
        end
        addr_rom = 8'h11;
        #1;
        checks++;
        if (in_rom_efficient !== 1'b0) begin
            errors++;
            $display("FAIL addr_change_gap: eff=%b want 0", in_rom_efficient);
        end
        fetch_check(8'h11);
    endtask

    task automatic test_ignored_start();
        wupc = 1'b0; ld_start = 1'b1; ld_addr = 8'h40;
        step();
        ld_start = 1'b0;
        checks++;
        if (ld_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_without_wupc: busy=%b want 0", ld_busy);
        end
    endtask

    task automatic test_abort_last();
        lw[0] = 24'h5A5A5A;
        do_load(8'h20, 1);
        wupc = 1'b1; ld_start = 1'b1; ld_addr = 8'h20;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_byte = 8'h01; ld_last = 1'b0;
        step();
        ld_byte = 8'h02; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if (ld_err !== 1'b1 || ld_busy !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("FAIL abort_last: err=%b busy=%b cnt=%0d want 1 0 0", ld_err, ld_busy, ld_count);
        end
        fetch_check(8'h20);
    endtask

    task automatic test_abort_wupc();
        wupc = 1'b1; ld_start = 1'b1; ld_addr = 8'h21;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_byte = 8'h77;
        step();
        ld_valid = 1'b0;
        wupc = 1'b0;
        step();
        checks++;
        if (ld_err !== 1'b1 || ld_busy !== 1'b0 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_wupc: err=%b busy=%b rdy=%b want 1 0 0", ld_err, ld_busy, ld_ready);
        end
        fetch_check(8'h10);
    endtask

    task automatic test_wrap();
        lw[0] = WW'($urandom_range(0, 24'hFFFFFF));
        lw[1] = WW'($urandom_range(0, 24'hFFFFFF));
        do_load(8'hFF, 2);
        fetch_check(8'hFF);
        fetch_check(8'h00);
    endtask

    task automatic test_reset_mid_load();
        addr_rom = 8'h10;
        step();
        lw[0] = 24'hC0FFEE;
        lw[1] = 24'hDEAD01;
        wupc = 1'b1; ld_start = 1'b1; ld_addr = 8'h30;
        step();
        ld_start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            ld_valid = (b != 3);
            ld_byte  = (b < 3) ? lw[0][23 - 8*b -: 8] : lw[1][23 - 8*(b-4) -: 8];
            step();
        end
        ld_valid = 1'b1; ld_byte = lw[1][15:8];
        step();
        ld_valid = 1'b0;
        checks++;
        if (ld_count !== 8'd1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_b2: cnt=%0d rdy=%b want 1 1", ld_count, ld_ready);
        end
        model[8'h30] = lw[0];
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (in_rom !== '0 || in_rom_efficient !== 1'b0 || ld_ready !== 1'b0 ||
            ld_busy !== 1'b0 || ld_err !== 1'b0 || ld_count !== '0) begin
            errors++;
            $display("FAIL async_reset: rom=%h eff=%b rdy=%b busy=%b err=%b cnt=%h want all 0",
                     in_rom, in_rom_efficient, ld_ready, ld_busy, ld_err, ld_count);
        end
        @(negedge clk);
        rst = 1'b1;
        fetch_check(8'h30);
        fetch_check(8'h10);
        fetch_check(8'h11);
    endtask

    initial begin
        test_reset();
        test_load_and_fetch();
        test_addr_change();
        test_ignored_start();
        test_abort_last();
        test_abort_wupc();
        test_wrap();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
